// File: rtl/div_pkg.sv
// div_pkg: shared constants for the sequential restoring divider.
package div_pkg;
    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    localparam logic [DIV_W-1:0] DIV_Z_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/sub_step_33.sv
// sub_step_33: combinational subtractor for one restoring-division step.
module sub_step_33 #(
    parameter int N = 33
) (
    input  logic [N-1:0] min_i,
    input  logic [N-1:0] sub_i,
    output logic [N-1:0] diff_o,
    output logic         borrow_o
);
    assign {borrow_o, diff_o} = {1'b0, min_i} - {1'b0, sub_i};
endmodule

// File: rtl/seq_divider_32.sv
// seq_divider_32: unsigned 32-bit divider, one restoring step per clock.
module seq_divider_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    logic [1:0]           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     q_q, q_d, d_q, d_d;
    logic [WIDTH:0]       r_q, r_d, shifted, diff;
    logic                 dbz_q, dbz_d, borrow, zero_div;

    assign shifted  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign zero_div = divisor == '0;

    sub_step_33 #(.N(WIDTH + 1)) u_sub (
        .min_i   (shifted),
        .sub_i   ({1'b0, d_q}),
        .diff_o  (diff),
        .borrow_o(borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        dbz_d   = dbz_q;
        if (state_q == DIV_IDLE) begin
            if (start) begin
                // A zero divisor short-circuits straight to the defined result.
                q_d     = zero_div ? WIDTH'(DIV_Z_QUOT) : dividend;
                r_d     = zero_div ? {1'b0, dividend} : '0;
                d_d     = divisor;
                cnt_d   = '0;
                dbz_d   = zero_div;
                state_d = zero_div ? DIV_DONE : DIV_RUN;
            end
        end else if (state_q == DIV_RUN) begin
            r_d     = borrow ? shifted : diff;
            q_d     = {q_q[WIDTH-2:0], ~borrow};
            cnt_d   = cnt_q + DIV_CNT_W'(1);
            state_d = (cnt_q == '1) ? DIV_DONE : DIV_RUN;
        end else begin
            state_d = DIV_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = state_q != DIV_IDLE;
    assign done        = state_q == DIV_DONE;
    assign quotient    = q_q;
    assign remainder   = r_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_32.sv
// tb_seq_divider_32: directed self-checking bench for seq_divider_32.
module tb_seq_divider_32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int vectors = 0;
    int miscompares = 0;

    seq_divider_32 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
    endtask

    // Called at the negedge after the accepting edge; returns when back in IDLE.
    task automatic wait_done(output int lat, output int bcnt);
        lat = -1; bcnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (done && lat < 0) lat = i;
            if (!busy) break;
            bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h, required all 0", busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eq, input logic [31:0] er);
        int lat, bcnt;
        start_div(a, b);
        wait_done(lat, bcnt);
        vectors++;
        if (quotient !== eq || remainder !== er || div_by_zero !== 1'b0 || lat != 32) begin
            miscompares++;
            $display("FAIL %s: q=%0d r=%0d dbz=%b lat=%0d, required q=%0d r=%0d dbz=0 lat=32", name, quotient, remainder, div_by_zero, lat, eq, er);
        end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        start_div(32'd100, 32'd7);
        wait_done(lat, bcnt);
        vectors++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_100_7: q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
        end
        vectors++;
        if (lat != 32 || bcnt != 33) begin
            miscompares++;
            $display("FAIL basic_timing: done_at=%0d busy_cycles=%0d, required 32 and 33", lat, bcnt);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b after DONE, required 0", done);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (quotient !== 32'd14 || remainder !== 32'd2) begin
            miscompares++;
            $display("FAIL hold_idle: q=%0d r=%0d, required q=14 r=2", quotient, remainder);
        end
    endtask

    task automatic test_edges;
        check_div("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        check_div("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        check_div("5_by_10", 32'd5, 32'd10, 32'd0, 32'd5);
        check_div("0_by_3", 32'd0, 32'd3, 32'd0, 32'd0);
        check_div("big_mixed", 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF);
    endtask

    task automatic test_div_zero;
        int lat, bcnt;
        start_div(32'd1234, 32'd0);
        wait_done(lat, bcnt);
        vectors++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd1234 || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL div_zero: q=%h r=%0d dbz=%b, required q=ffffffff r=1234 dbz=1", quotient, remainder, div_by_zero);
        end
        vectors++;
        if (lat != 0 || bcnt != 1) begin
            miscompares++;
            $display("FAIL div_zero_timing: done_at=%0d busy_cycles=%0d, required 0 and 1", lat, bcnt);
        end
        start_div(32'd9, 32'd2);
        vectors++;
        if (div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL dbz_clear: dbz=%b after accept, required 0", div_by_zero);
        end
        wait_done(lat, bcnt);
        vectors++;
        if (quotient !== 32'd4 || remainder !== 32'd1 || lat != 32) begin
            miscompares++;
            $display("FAIL after_zero: q=%0d r=%0d lat=%0d, required q=4 r=1 lat=32", quotient, remainder, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        @(negedge clk);
        start = 1'b1; dividend = 32'd200; divisor = 32'd9;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 33) begin
                vectors++;
                if (done !== 1'b1 || quotient !== 32'd22 || remainder !== 32'd2) begin
                    miscompares++;
                    $display("FAIL b2b_first: done=%b q=%0d r=%0d, required done=1 q=22 r=2", done, quotient, remainder);
                end
            end
            dividend = $urandom | 32'h1000; divisor = ($urandom & 32'hFF) | 32'h1;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: busy=%b after E33, required 0", busy);
        end
        dividend = 32'd77; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        wait_done(lat, bcnt);
        vectors++;
        if (quotient !== 32'd15 || remainder !== 32'd2 || lat != 32) begin
            miscompares++;
            $display("FAIL b2b_second: q=%0d r=%0d lat=%0d, required q=15 r=2 lat=32", quotient, remainder, lat);
        end
    endtask

    task automatic test_reset_abort;
        int seen;
        start_div(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: busy=%b done=%b q=%0d r=%0d, required all 0", busy, done, quotient, remainder);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: %0d active cycles after abort, required 0", seen);
        end
        check_div("after_abort", 32'd1000, 32'd3, 32'd333, 32'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
